// File: rtl/bldc_pkg.sv
// Shared encodings and the forward commutation table for the BLDC commutator.
package bldc_pkg;

    localparam int unsigned HALL_W = 3;

    // FSM state encodings (visible on the STATE port)
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_DEAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_FLT  = 2'b11;

    // Latched error codes, ordered by priority 01 > 10 > 11
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_EXT   = 2'b01;
    localparam logic [1:0] ERR_HALL  = 2'b10;
    localparam logic [1:0] ERR_STALL = 2'b11;

    // Hall codes that no rotor position can produce
    localparam logic [HALL_W-1:0] HALL_BAD_LO = 3'b000;
    localparam logic [HALL_W-1:0] HALL_BAD_HI = 3'b111;

    typedef struct packed {
        logic [2:0] hi;  // high-side phase, one-hot {C,B,A}
        logic [2:0] lo;  // low-side phase, one-hot {C,B,A}
    } phase_pair_t;

    function automatic logic hall_valid(input logic [HALL_W-1:0] h);
        return (h != HALL_BAD_LO) && (h != HALL_BAD_HI);
    endfunction

    // Forward six-step table; reverse is obtained by swapping hi and lo
    function automatic phase_pair_t sector_fwd(input logic [HALL_W-1:0] h);
        phase_pair_t p;
        case (h)
            3'b101:  p = '{hi: 3'b001, lo: 3'b010};  // A / B
            3'b100:  p = '{hi: 3'b001, lo: 3'b100};  // A / C
            3'b110:  p = '{hi: 3'b010, lo: 3'b100};  // B / C
            3'b010:  p = '{hi: 3'b010, lo: 3'b001};  // B / A
            3'b011:  p = '{hi: 3'b100, lo: 3'b001};  // C / A
            3'b001:  p = '{hi: 3'b100, lo: 3'b010};  // C / B
            default: p = '{hi: 3'b000, lo: 3'b000};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bldc_commutator_hall_sync.sv
// Hall input conditioning: two-flop synchronizer followed by a stability debounce.
// The debounced code moves to a new value only after the synchronized code has
// differed from it and stayed constant for DEB_CYC consecutive cycles.
module hall_sync
    import bldc_pkg::*;
#(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [HALL_W-1:0] hall_i,
    output logic [HALL_W-1:0] hall_o,
    output logic              chg_o
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);

    logic [HALL_W-1:0] s1_q, s2_q;
    logic [HALL_W-1:0] deb_q, deb_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              chg_q, chg_d;

    // Debounce: count cycles the synchronized code has held a new value
    always_comb begin
        deb_d = deb_q;
        cnt_d = 8'd0;
        chg_d = 1'b0;
        if (s2_q != deb_q) begin
            if (cnt_q == DEB_LAST) begin
                deb_d = s2_q;
                chg_d = 1'b1;
            end else if (s1_q == s2_q) begin
                // s2 is not about to change, so this cycle extends the run
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Synchronizer and debounce state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= '0;
            s2_q  <= '0;
            deb_q <= '0;
            cnt_q <= 8'd0;
            chg_q <= 1'b0;
        end else begin
            s1_q  <= hall_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    assign hall_o = deb_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation controller: sector selection, dead-time insertion,
// duty ramping toward the commanded value and latched fault handling.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned DEAD_CYC  = 8,
    parameter int unsigned RAMP_DIV  = 16,
    parameter int unsigned STALL_CYC = 1000000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        RUN,
    input  logic        DIR,
    input  logic [7:0]  DUTY_CMD,
    input  logic [2:0]  HALL,
    input  logic        FAULT,
    input  logic        PWM_IN,
    output logic [7:0]  PWM_DUTY,
    output logic        PWM_EN,
    output logic [2:0]  GATE_H,
    output logic [2:0]  GATE_L,
    output logic [1:0]  STATE,
    output logic [1:0]  ERR
);

    localparam logic [7:0]  DEAD_LAST  = 8'(DEAD_CYC - 1);
    localparam logic [15:0] PRE_LAST   = 16'(RAMP_DIV - 1);
    localparam logic [23:0] STALL_LAST = 24'(STALL_CYC - 1);

    logic [2:0]  deb_hall;
    logic        hall_chg;
    logic        hall_ok;
    logic        stall_hit;
    logic        active;
    phase_pair_t pair;

    logic [1:0]  state_q, state_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  dead_q, dead_d;
    logic [15:0] pre_q, pre_d;
    logic [23:0] stall_q, stall_d;
    logic [7:0]  duty_q, duty_d;
    logic        en_q, en_d;
    logic [2:0]  hi_q, hi_d;
    logic [2:0]  lo_q, lo_d;
    logic [2:0]  sec_hall_q, sec_hall_d;
    logic        dir_q, dir_d;

    hall_sync #(
        .DEB_CYC (DEB_CYC)
    ) u_hall_sync (
        .clk_i  (CLK),
        .rst_ni (RSTN),
        .hall_i (HALL),
        .hall_o (deb_hall),
        .chg_o  (hall_chg)
    );

    assign hall_ok   = hall_valid(deb_hall);
    assign active    = (state_q == ST_DEAD) || (state_q == ST_RUN);
    // A Hall edge in the same cycle restarts the count instead of faulting
    assign stall_hit = (stall_q == STALL_LAST) && !hall_chg;

    // FSM next state and error latch; fault causes checked in priority order
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (FAULT) begin
                    state_d = ST_FLT;
                    err_d   = ERR_EXT;
                end else if (RUN && !hall_ok) begin
                    state_d = ST_FLT;
                    err_d   = ERR_HALL;
                end else if (RUN) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD, ST_RUN: begin
                if (FAULT) begin
                    state_d = ST_FLT;
                    err_d   = ERR_EXT;
                end else if (!hall_ok) begin
                    state_d = ST_FLT;
                    err_d   = ERR_HALL;
                end else if (stall_hit) begin
                    state_d = ST_FLT;
                    err_d   = ERR_STALL;
                end else if (!RUN) begin
                    state_d = ST_IDLE;
                end else if (state_q == ST_DEAD) begin
                    if (dead_q == DEAD_LAST) state_d = ST_RUN;
                end else if ((deb_hall != sec_hall_q) || (DIR != dir_q)) begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                if (!RUN && !FAULT) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
        endcase
    end

    // Gate masks: latched on DEAD->RUN, cleared whenever the next state is not RUN
    always_comb begin
        pair       = sector_fwd(deb_hall);
        sec_hall_d = sec_hall_q;
        dir_d      = dir_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (state_d != ST_RUN) begin
            hi_d = 3'b000;
            lo_d = 3'b000;
        end else if (state_q != ST_RUN) begin
            sec_hall_d = deb_hall;
            dir_d      = DIR;
            hi_d       = DIR ? pair.lo : pair.hi;
            lo_d       = DIR ? pair.hi : pair.lo;
        end
    end

    // Dead-time, ramp prescaler, stall counter and duty ramp
    always_comb begin
        dead_d  = (state_q == ST_DEAD) ? dead_q + 8'd1 : 8'd0;
        pre_d   = (!active || pre_q == PRE_LAST) ? 16'd0 : pre_q + 16'd1;
        stall_d = (!active || hall_chg) ? 24'd0 : stall_q + 24'd1;
        en_d    = (state_d == ST_DEAD) || (state_d == ST_RUN);
        duty_d  = duty_q;
        if (!en_d) begin
            duty_d = 8'd0;
        end else if (active && pre_q == PRE_LAST) begin
            // Step toward the command; the comparison keeps it from wrapping
            if (duty_q < DUTY_CMD)      duty_d = duty_q + 8'd1;
            else if (duty_q > DUTY_CMD) duty_d = duty_q - 8'd1;
        end
    end

    // Controller state registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            dead_q     <= 8'd0;
            pre_q      <= 16'd0;
            stall_q    <= 24'd0;
            duty_q     <= 8'd0;
            en_q       <= 1'b0;
            hi_q       <= 3'b000;
            lo_q       <= 3'b000;
            sec_hall_q <= 3'b000;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            dead_q     <= dead_d;
            pre_q      <= pre_d;
            stall_q    <= stall_d;
            duty_q     <= duty_d;
            en_q       <= en_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            sec_hall_q <= sec_hall_d;
            dir_q      <= dir_d;
        end
    end

    // High side is chopped by the PWM generator; hi/lo masks are disjoint by table
    assign GATE_H   = hi_q & {3{PWM_IN}};
    assign GATE_L   = lo_q;
    assign PWM_DUTY = duty_q;
    assign PWM_EN   = en_q;
    assign STATE    = state_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator: start-up, ramp, commutation, reverse,
// fault latching/clearing, stall detection and asynchronous reset.
module tb_bldc_commutator;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       RUN;
    logic       DIR;
    logic [7:0] DUTY_CMD;
    logic [2:0] HALL;
    logic       FAULT;
    logic       PWM_IN;
    logic [7:0] PWM_DUTY;
    logic       PWM_EN;
    logic [2:0] GATE_H;
    logic [2:0] GATE_L;
    logic [1:0] STATE;
    logic [1:0] ERR;

    int checks   = 0;
    int failures = 0;

    bldc_commutator #(
        .DEB_CYC   (4),
        .DEAD_CYC  (8),
        .RAMP_DIV  (16),
        .STALL_CYC (200)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .RUN      (RUN),
        .DIR      (DIR),
        .DUTY_CMD (DUTY_CMD),
        .HALL     (HALL),
        .FAULT    (FAULT),
        .PWM_IN   (PWM_IN),
        .PWM_DUTY (PWM_DUTY),
        .PWM_EN   (PWM_EN),
        .GATE_H   (GATE_H),
        .GATE_L   (GATE_L),
        .STATE    (STATE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, checking for shoot-through each cycle
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("no_shoot_through", {29'd0, GATE_H & GATE_L}, 32'd0);
        end
    endtask

    initial begin
        RSTN = 1'b0; RUN = 1'b0; DIR = 1'b0; DUTY_CMD = 8'd10;
        HALL = 3'b101; FAULT = 1'b0; PWM_IN = 1'b0;
        #1;
        chk("rst_state", STATE, 2'b00);
        chk("rst_err", ERR, 2'b00);
        chk("rst_duty", PWM_DUTY, 8'd0);
        chk("rst_en", PWM_EN, 1'b0);
        chk("rst_gates", {GATE_H, GATE_L}, 6'b0);
        step(2);
        RSTN = 1'b1;
        step(10);
        chk("idle_state", STATE, 2'b00);
        chk("idle_err", ERR, 2'b00);

        // Start: 8 dead cycles then RUN on sector 101 (A/B)
        RUN = 1'b1;
        step(1);
        chk("start_dead", STATE, 2'b01);
        chk("start_dead_en", PWM_EN, 1'b1);
        chk("start_dead_gates", {GATE_H, GATE_L}, 6'b0);
        step(7);
        chk("start_dead_last", STATE, 2'b01);
        step(1);
        chk("start_run", STATE, 2'b10);
        chk("start_gl", GATE_L, 3'b010);
        chk("start_gh_pwm0", GATE_H, 3'b000);
        PWM_IN = 1'b1;
        #1;
        chk("start_gh_pwm1", GATE_H, 3'b001);

        // Ramp: one step per 16 cycles since DEAD entry
        step(151);
        chk("ramp_160", PWM_DUTY, 8'd9);
        step(1);
        chk("ramp_161", PWM_DUTY, 8'd10);
        step(19);
        chk("ramp_hold", PWM_DUTY, 8'd10);
        chk("ramp_hold_run", STATE, 2'b10);

        // Commutation 101 -> 100
        HALL = 3'b100;
        step(6);
        chk("comm_pre_state", STATE, 2'b10);
        chk("comm_pre_gl", GATE_L, 3'b010);
        step(1);
        chk("comm_dead", STATE, 2'b01);
        chk("comm_dead_gates", {GATE_H, GATE_L}, 6'b0);
        step(7);
        chk("comm_dead_last", {GATE_H, GATE_L}, 6'b0);
        step(1);
        chk("comm_run", STATE, 2'b10);
        chk("comm_gl", GATE_L, 3'b100);
        chk("comm_gh", GATE_H, 3'b001);

        // Reverse on sector 110: high C, low B
        step(1);
        DIR = 1'b1;
        HALL = 3'b110;
        step(8);
        chk("rev_dead", STATE, 2'b01);
        step(1);
        chk("rev_run", STATE, 2'b10);
        chk("rev_gh", GATE_H, 3'b100);
        chk("rev_gl", GATE_L, 3'b010);
        chk("rev_duty", PWM_DUTY, 8'd10);

        // Ramp down by one on the next prescaler wrap
        DUTY_CMD = 8'd9;
        step(5);
        chk("ramp_down", PWM_DUTY, 8'd9);

        // External fault and clearing rules
        FAULT = 1'b1;
        step(1);
        chk("ext_state", STATE, 2'b11);
        chk("ext_err", ERR, 2'b01);
        chk("ext_gates", {GATE_H, GATE_L}, 6'b0);
        chk("ext_en", PWM_EN, 1'b0);
        chk("ext_duty", PWM_DUTY, 8'd0);
        RUN = 1'b0;
        step(2);
        chk("ext_hold_fault", {STATE, ERR}, 4'b1101);
        FAULT = 1'b0;
        RUN = 1'b1;
        step(2);
        chk("ext_hold_run", {STATE, ERR}, 4'b1101);
        RUN = 1'b0;
        step(1);
        chk("ext_clear", {STATE, ERR}, 4'b0000);

        // Invalid Hall while running
        RUN = 1'b1;
        step(9);
        chk("bad_run", STATE, 2'b10);
        HALL = 3'b111;
        step(6);
        chk("bad_pre", STATE, 2'b10);
        step(1);
        chk("bad_state", STATE, 2'b11);
        chk("bad_err", ERR, 2'b10);
        chk("bad_gates", {GATE_H, GATE_L}, 6'b0);
        RUN = 1'b0;
        step(1);
        chk("bad_clear", {STATE, ERR}, 4'b0000);
        RUN = 1'b1;
        step(1);
        chk("bad_idle_start", {STATE, ERR}, 4'b1110);
        RUN = 1'b0;
        step(1);
        chk("bad_idle_clear", {STATE, ERR}, 4'b0000);

        // Stall: Hall edge at cycle 100 restarts the 200-cycle count
        HALL = 3'b011;
        step(8);
        RUN = 1'b1;
        step(100);
        chk("stall_run100", STATE, 2'b10);
        HALL = 3'b001;
        step(150);
        chk("stall_reset_state", STATE, 2'b10);
        chk("stall_reset_err", ERR, 2'b00);
        step(56);
        chk("stall_pre", STATE, 2'b10);
        step(1);
        chk("stall_state", STATE, 2'b11);
        chk("stall_err", ERR, 2'b11);
        RUN = 1'b0;
        step(1);
        chk("stall_clear", {STATE, ERR}, 4'b0000);

        // Asynchronous reset in the middle of RUN
        RUN = 1'b1;
        step(9);
        chk("mid_run_gh", GATE_H, 3'b010);
        chk("mid_run_gl", GATE_L, 3'b100);
        #2;
        RSTN = 1'b0;
        #1;
        chk("mid_rst_state", STATE, 2'b00);
        chk("mid_rst_gates", {GATE_H, GATE_L}, 6'b0);
        chk("mid_rst_en_duty", {PWM_EN, PWM_DUTY}, 9'd0);
        chk("mid_rst_err", ERR, 2'b00);
        RUN = 1'b0;
        step(1);
        RSTN = 1'b1;
        step(2);
        chk("post_rst_state", STATE, 2'b00);
        chk("post_rst_gates", {GATE_H, GATE_L}, 6'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
